// File: rtl/suma_control.sv
// suma_control: keypad-driven sequencer for the 4-digit BCD adder.
//   Collects BCD digits into an entry register. Keeps a running accumulator.
//   Issues the adder's suma/finalizar strobes, waits for and captures the
//   adder's result, and selects what the 7-segment display path shows.
//
// Parameters:
//   ADD_LAT   cycles from the suma pulse until resultado is valid (1..15)
//   NDIG      BCD digits per operand (fixed at 4)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   0-9 digit, A add, B equals, C clear, D-F ignored
//   key_ready  1 = a key presented this cycle is accepted
//   numero     entry operand to the adder
//   numero_sv  accumulator operand to the adder
//   suma       one-cycle adder start strobe
//   finalizar  one-cycle end-of-calculation strobe
//   resultado  BCD result from the adder
//   disp       digits to display, [3] = most significant
//   disp_sel   0 = showing entry, 1 = showing accumulator
//   ndig       number of digits currently held in entry (0..4)
module suma_control #(
   parameter int unsigned ADD_LAT = 2,
   parameter int unsigned NDIG    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            key_valid,
   input  logic [3:0]      key_code,
   output logic            key_ready,
   output logic [3:0][3:0] numero,
   output logic [3:0][3:0] numero_sv,
   output logic            suma,
   output logic            finalizar,
   input  logic [3:0][3:0] resultado,
   output logic [3:0][3:0] disp,
   output logic            disp_sel,
   output logic [2:0]      ndig
);

   typedef enum logic [2:0] {
      StEntry,
      StAddReq,
      StAddWait,
      StCapture,
      StDone
   } state_e;

   localparam logic [3:0] KeyAdd = 4'hA;
   localparam logic [3:0] KeyEq  = 4'hB;
   localparam logic [3:0] KeyClr = 4'hC;

   state_e          state_q;
   logic [3:0][3:0] entry_q;
   logic [3:0][3:0] acc_q;
   logic [3:0][3:0] disp_q;
   logic [2:0]      ndig_q;
   logic [3:0]      cnt_q;
   logic            op_eq_q;
   logic            suma_q;
   logic            fin_q;
   logic            sel_q;
   logic            ready_q;

   logic accept;
   logic is_digit;

   assign accept   = key_valid & ready_q;
   assign is_digit = (key_code <= 4'd9);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StEntry;
         entry_q <= '0;
         acc_q   <= '0;
         disp_q  <= '0;
         ndig_q  <= 3'd0;
         cnt_q   <= 4'd0;
         op_eq_q <= 1'b0;
         suma_q  <= 1'b0;
         fin_q   <= 1'b0;
         sel_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         // Strobes default low so each is high for one cycle only.
         suma_q <= 1'b0;
         fin_q  <= 1'b0;
         // Display follows its source one cycle later.
         disp_q <= sel_q ? acc_q : entry_q;

         unique case (state_q)
            StEntry: begin
               if (accept) begin
                  if (is_digit) begin
                     sel_q <= 1'b0;
                     if (ndig_q < 3'(NDIG)) begin
                        entry_q <= {entry_q[2:0], key_code};
                        ndig_q  <= ndig_q + 3'd1;
                     end
                  end else if (key_code == KeyAdd || key_code == KeyEq) begin
                     // An empty entry still adds, with operand 0.
                     op_eq_q <= (key_code == KeyEq);
                     suma_q  <= 1'b1;
                     ready_q <= 1'b0;
                     state_q <= StAddReq;
                  end else if (key_code == KeyClr) begin
                     entry_q <= '0;
                     acc_q   <= '0;
                     ndig_q  <= 3'd0;
                     sel_q   <= 1'b0;
                  end
               end
            end

            StAddReq: begin
               cnt_q   <= 4'(ADD_LAT - 1);
               state_q <= StAddWait;
            end

            StAddWait: begin
               if (cnt_q == 4'd0) begin
                  fin_q   <= op_eq_q;
                  state_q <= StCapture;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            StCapture: begin
               acc_q   <= resultado;
               entry_q <= '0;
               ndig_q  <= 3'd0;
               sel_q   <= 1'b1;
               ready_q <= 1'b1;
               state_q <= op_eq_q ? StDone : StEntry;
            end

            StDone: begin
               if (accept) begin
                  if (is_digit) begin
                     // A digit after a result starts a fresh calculation.
                     acc_q   <= '0;
                     entry_q <= {12'h000, key_code};
                     ndig_q  <= 3'd1;
                     sel_q   <= 1'b0;
                     state_q <= StEntry;
                  end else if (key_code == KeyAdd) begin
                     // Chain on the shown result: accumulator kept, entry 0.
                     entry_q <= '0;
                     ndig_q  <= 3'd0;
                     op_eq_q <= 1'b0;
                     suma_q  <= 1'b1;
                     ready_q <= 1'b0;
                     state_q <= StAddReq;
                  end else if (key_code == KeyClr) begin
                     entry_q <= '0;
                     acc_q   <= '0;
                     ndig_q  <= 3'd0;
                     sel_q   <= 1'b0;
                     state_q <= StEntry;
                  end
               end
            end

            default: begin
               state_q <= StEntry;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign key_ready = ready_q;
   assign numero    = entry_q;
   assign numero_sv = acc_q;
   assign suma      = suma_q;
   assign finalizar = fin_q;
   assign disp      = disp_q;
   assign disp_sel  = sel_q;
   assign ndig      = ndig_q;

endmodule

// File: tb/tb_suma_control.sv
// tb_suma_control: randomized, scoreboard-checked bench for suma_control.
//   A decimal-integer reference model predicts adder requests, results and
//   the settled entry/accumulator/display state; a monitor process compares
//   the DUT against the queued expectations.
module tb_suma_control;

   localparam int unsigned AddLat = 2;

   typedef logic [3:0][3:0] bcd_t;
   typedef struct {
      int unsigned num;
      int unsigned sv;
   } op_t;
   typedef struct {
      int unsigned entry;
      int unsigned acc;
      int unsigned ndig;
      int unsigned sel;
   } snap_t;

   logic       clk       = 1'b0;
   logic       rst       = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code  = 4'h0;
   logic       key_ready;
   bcd_t       numero;
   bcd_t       numero_sv;
   bcd_t       disp;
   bcd_t       resultado = '0;
   logic       suma;
   logic       finalizar;
   logic       disp_sel;
   logic [2:0] ndig;

   int checks = 0;
   int errors = 0;

   op_t         exp_suma[$];
   int unsigned exp_fin[$];
   snap_t       exp_snap[$];

   // Reference model state (decimal integers).
   int unsigned m_entry = 0;
   int unsigned m_acc   = 0;
   int unsigned m_ndig  = 0;
   int unsigned m_sel   = 0;
   bit          m_done  = 1'b0;

   suma_control #(
      .ADD_LAT(AddLat),
      .NDIG   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_ready(key_ready),
      .numero   (numero),
      .numero_sv(numero_sv),
      .suma     (suma),
      .finalizar(finalizar),
      .resultado(resultado),
      .disp     (disp),
      .disp_sel (disp_sel),
      .ndig     (ndig)
   );

   always #5 clk = ~clk;

   function automatic bcd_t to_bcd(input int unsigned v);
      bcd_t b;
      int unsigned t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         b[i] = 4'(t % 10);
         t    = t / 10;
      end
      return b;
   endfunction

   function automatic int unsigned from_bcd(input bcd_t b);
      int unsigned v;
      v = 0;
      for (int i = 3; i >= 0; i--) v = v * 10 + 32'(b[i]);
      return v;
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Adder stand-in: garbage until ADD_LAT cycles after suma, then the sum.
   int unsigned add_cnt = 0;
   bcd_t        add_res = '0;
   always @(posedge clk) begin
      if (rst && suma) begin
         add_res = to_bcd((from_bcd(numero) + from_bcd(numero_sv)) % 10000);
         add_cnt = AddLat;
         #1 resultado = to_bcd((from_bcd(add_res) + 1) % 10000);
      end else if (add_cnt != 0) begin
         add_cnt--;
         if (add_cnt == 0) begin
            #1 resultado = add_res;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a strobe or a
   // settled-state snapshot is queued.
   int unsigned cyc      = 0;
   int unsigned suma_cyc = 0;
   int unsigned fin_pend = 0;
   int unsigned fin_val  = 0;
   bit          prev_suma = 1'b0;
   bit          prev_fin  = 1'b0;
   op_t         mon_op;
   snap_t       mon_snap;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         fin_pend  = 0;
         prev_suma = 1'b0;
         prev_fin  = 1'b0;
      end else begin
         if (suma) begin
            check("strobe_exclusive", 32'(finalizar), 0);
            check("suma_single_cycle", 32'(prev_suma), 0);
            if (exp_suma.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_suma: suma=1 numero=%h numero_sv=%h, required no strobe",
                        numero, numero_sv);
            end else begin
               mon_op = exp_suma.pop_front();
               check("suma_numero", from_bcd(numero), mon_op.num);
               check("suma_numero_sv", from_bcd(numero_sv), mon_op.sv);
            end
            suma_cyc = cyc;
         end
         if (finalizar) begin
            check("fin_single_cycle", 32'(prev_fin), 0);
            if (exp_fin.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_finalizar: finalizar=1, required no strobe");
            end else begin
               fin_val = exp_fin.pop_front();
               check("fin_latency", cyc - suma_cyc, AddLat + 1);
               fin_pend = 2;
            end
         end else if (fin_pend != 0) begin
            fin_pend--;
            if (fin_pend == 0) begin
               check("fin_acc", from_bcd(numero_sv), fin_val);
               check("fin_disp", from_bcd(disp), fin_val);
               check("fin_disp_sel", 32'(disp_sel), 1);
            end
         end
         if (exp_snap.size() != 0) begin
            mon_snap = exp_snap.pop_front();
            check("snap_entry", from_bcd(numero), mon_snap.entry);
            check("snap_acc", from_bcd(numero_sv), mon_snap.acc);
            check("snap_ndig", 32'(ndig), mon_snap.ndig);
            check("snap_disp_sel", 32'(disp_sel), mon_snap.sel);
            check("snap_disp", from_bcd(disp), (mon_snap.sel != 0) ? mon_snap.acc : mon_snap.entry);
            check("snap_key_ready", 32'(key_ready), 1);
         end
         prev_suma = suma;
         prev_fin  = finalizar;
      end
   end

   task automatic model_reset();
      m_entry = 0;
      m_acc   = 0;
      m_ndig  = 0;
      m_sel   = 0;
      m_done  = 1'b0;
   endtask

   // Calculator behaviour in decimal terms, one accepted key at a time.
   task automatic model_apply(input logic [3:0] k);
      int unsigned r;
      if (k == 4'hC) begin
         model_reset();
      end else if (k >= 4'hD) begin
         r = 0;
      end else if (!m_done) begin
         if (k <= 4'd9) begin
            if (m_ndig < 4) begin
               m_entry = m_entry * 10 + 32'(k);
               m_ndig++;
            end
            m_sel = 0;
         end else begin
            exp_suma.push_back('{m_entry, m_acc});
            r       = (m_entry + m_acc) % 10000;
            m_acc   = r;
            m_entry = 0;
            m_ndig  = 0;
            m_sel   = 1;
            if (k == 4'hB) begin
               m_done = 1'b1;
               exp_fin.push_back(r);
            end
         end
      end else begin
         if (k <= 4'd9) begin
            m_acc   = 0;
            m_entry = 32'(k);
            m_ndig  = 1;
            m_sel   = 0;
            m_done  = 1'b0;
         end else if (k == 4'hA) begin
            exp_suma.push_back('{0, m_acc});
            m_acc   = m_acc % 10000;
            m_entry = 0;
            m_ndig  = 0;
            m_sel   = 1;
            m_done  = 1'b0;
         end
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_key_ready", 32'(key_ready), 1);
      check("rst_numero", from_bcd(numero), 0);
      check("rst_numero_sv", from_bcd(numero_sv), 0);
      check("rst_suma", 32'(suma), 0);
      check("rst_finalizar", 32'(finalizar), 0);
      check("rst_disp", from_bcd(disp), 0);
      check("rst_disp_sel", 32'(disp_sel), 0);
      check("rst_ndig", 32'(ndig), 0);
   endtask

   // mode 0: plain key; 1: inject a digit while busy; 2: reset mid ADD_WAIT.
   task automatic send_key(input logic [3:0] k, input int mode);
      int guard;
      guard = 0;
      while (key_ready !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) begin
         checks++;
         errors++;
         $display("FAIL key_ready_timeout: key_ready=%b, required 1", key_ready);
      end
      model_apply(k);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'($urandom_range(0, 15));
      if (mode == 1) begin
         @(negedge clk);
         check("busy_key_ready", 32'(key_ready), 0);
         key_valid = 1'b1;
         key_code  = 4'd7;
         @(negedge clk);
         key_valid = 1'b0;
      end else if (mode == 2) begin
         @(negedge clk);
         #3 rst = 1'b0;
         #1 check_reset_outputs();
         exp_suma.delete();
         exp_fin.delete();
         model_reset();
         @(negedge clk);
         @(negedge clk);
         rst = 1'b1;
         repeat (12) @(negedge clk);
      end
      repeat (AddLat + 5) @(negedge clk);
      exp_snap.push_back('{m_entry, m_acc, m_ndig, m_sel});
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      #1 check_reset_outputs();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Digit entry, fifth digit ignored.
      send_key(4'h1, 0);
      send_key(4'h2, 0);
      send_key(4'h3, 0);
      send_key(4'h4, 0);
      send_key(4'h5, 0);
      send_key(4'hC, 0);
      // 12 + 30 = 42.
      send_key(4'h1, 0);
      send_key(4'h2, 0);
      send_key(4'hA, 0);
      send_key(4'h3, 0);
      send_key(4'h0, 0);
      send_key(4'hB, 0);
      // Digit after a result starts over; chaining on a result.
      send_key(4'h5, 0);
      send_key(4'hC, 0);
      send_key(4'h4, 0);
      send_key(4'h2, 0);
      send_key(4'hB, 0);
      send_key(4'hB, 0);
      send_key(4'hA, 0);
      // Key dropped while busy.
      send_key(4'h1, 0);
      send_key(4'hA, 1);
      // Ignored code, then clear.
      send_key(4'hC, 0);
      send_key(4'h9, 0);
      send_key(4'h9, 0);
      send_key(4'hD, 0);
      send_key(4'hC, 0);
      // Async reset mid ADD_WAIT, then normal operation resumes.
      send_key(4'h1, 0);
      send_key(4'h2, 0);
      send_key(4'hB, 2);
      send_key(4'h3, 0);
      send_key(4'hA, 0);

      for (int i = 0; i < 80; i++) begin
         logic [3:0] k;
         int unsigned r;
         int mode;
         r = $urandom_range(0, 9);
         if (r <= 5) k = 4'($urandom_range(0, 9));
         else if (r <= 7) k = 4'hA;
         else if (r == 8) k = 4'hB;
         else k = 4'($urandom_range(12, 15));
         mode = 0;
         if ((k == 4'hA || (k == 4'hB && !m_done)) && $urandom_range(0, 3) == 0) mode = 1;
         send_key(k, mode);
      end

      repeat (5) @(negedge clk);
      check("suma_queue_drained", exp_suma.size(), 0);
      check("fin_queue_drained", exp_fin.size(), 0);
      check("snap_queue_drained", exp_snap.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/suma_control.md
Name: suma_control

Overview:
- Keypad-driven sequencer for the 4-digit BCD adder (Suma_datos) in the calculator datapath.
- Collects up to 4 BCD digits into an entry register and holds a running accumulator.
- Issues the adder's suma/finalizar strobes, waits for the result and captures it.
- Selects what the 7-segment display path shows.

Parameters:
- ADD_LAT, 2, clock cycles from the suma pulse until resultado is valid and captured (range 1..15).
- NDIG, 4, BCD digits per operand; fixed at 4 for this revision.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle strobe: key_code is valid
- key_code  in  4  0x0-0x9 digit; 0xA add; 0xB equals; 0xC clear; 0xD-0xF ignored
- key_ready  out  1  1 = key accepted this cycle
- numero  out  [3:0][3:0]  entry operand to adder
- numero_sv  out  [3:0][3:0]  accumulator operand to adder
- suma  out  1  one-cycle adder start strobe
- finalizar  out  1  one-cycle end-of-calculation strobe
- resultado  in  [3:0][3:0]  adder BCD result
- disp  out  [3:0][3:0]  digits to display, [3] = most significant
- disp_sel  out  1  0 = showing entry, 1 = showing accumulator
- ndig  out  3  digits currently in entry (0..4)

Behaviour:
- Reset (rst=0, async): state=ENTRY; entry, acc, disp, numero, numero_sv = 0; ndig=0; suma, finalizar, disp_sel = 0; key_ready=1.
- numero always equals entry; numero_sv always equals acc (registered, stable during ADD_WAIT).
- States: ENTRY, ADD_REQ, ADD_WAIT, CAPTURE, DONE.
- key_ready=1 in ENTRY and DONE, 0 otherwise.
- key_valid while key_ready=0: dropped, no side effect.
- ENTRY, digit d:
  - ndig<4: entry <= {entry[2:0], d}; ndig++.
  - ndig==4: key ignored, entry unchanged.
  - disp_sel=0.
- ENTRY, 0xA or 0xB:
  - latch op (add / equals); go to ADD_REQ.
  - ndig==0: still adds (operand 0).
- ADD_REQ:
  - suma=1 for exactly this cycle; load wait counter with ADD_LAT-1; go to ADD_WAIT.
- ADD_WAIT:
  - counter decrements each cycle; at 0 go to CAPTURE.
  - Total latency: key accept to acc update = ADD_LAT+2 cycles.
- CAPTURE:
  - acc <= resultado; entry <= 0; ndig <= 0; disp_sel <= 1.
  - op=add: go to ENTRY.
  - op=equals: finalizar=1 this cycle; go to DONE.
- DONE, digit d:
  - acc <= 0; entry <= {0,0,0,d}; ndig <= 1; disp_sel <= 0; go to ENTRY.
- DONE, 0xA: chain on the result (acc kept, entry=0); go to ADD_REQ with op=add.
- DONE, 0xB: ignored.
- 0xC in ENTRY or DONE: entry=0; acc=0; ndig=0; disp_sel=0; go to ENTRY. Clear is not accepted in ADD_* states.
- 0xD-0xF: accepted (key_ready stays 1), no effect.
- disp = disp_sel ? acc : entry, registered, updates the cycle after the source changes.
- Overflow: acc is resultado as produced by the adder (modulo 10000); no overflow flag in this revision.
- Only one of suma/finalizar is high in any cycle; each strobe is never high for 2 consecutive cycles.
- Reset mid ADD_WAIT: immediate return to reset values; no suma or finalizar after reset release until a new op key.
- Digit bus is never validated beyond 0x9: codes 0xA-0xF are commands.

Test Plan:
- Digit entry: reset; keys 1,2,3,4,5 -> entry=1234, ndig=4, 5 ignored, disp=1234, disp_sel=0, no suma.
- Add then equals: keys 1,2,A,3,0,B with adder model (ADD_LAT=2) -> first suma with numero=0012/numero_sv=0000; acc=0012; second suma numero=0030/numero_sv=0012; finalizar one cycle; acc=disp=0042, disp_sel=1; suma->capture spacing exactly ADD_LAT+1 cycles.
- Busy drop: key 7 injected during ADD_WAIT -> key_ready=0, entry and acc unchanged after capture.
- DONE behaviour: after 0042 shown, key 5 -> acc=0, entry=0005, disp_sel=0; repeat to DONE, key A -> suma with numero_sv=0042, numero=0000.
- Clear and ignored codes: entry 0099, key D -> no change; key C -> entry=acc=0, ndig=0, disp=0000.
- Async reset: assert rst=0 mid ADD_WAIT between clock edges -> all outputs reset immediately; after release no strobe until the next A/B key.
